// File: rtl/key_scan_pkg.sv
// key_scan_pkg: shared channel state type and width helper for the key scanner
package key_scan_pkg;
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} ch_state_t;
    function automatic int code_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/key_scan_ch.sv
// key_scan_ch: one key channel - synchroniser, tick debounce, hold/long/repeat FSM
module key_scan_ch
    import key_scan_pkg::*;
#(
    parameter int DEB_TICKS    = 20,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int ACTIVE_HIGH  = 1
) (
    input  logic clk_in,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic lvl,
    output logic press,
    output logic rel,
    output logic lng,
    output logic rpt
);
    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int LW = $clog2(LONG_TICKS + 1);
    localparam int RW = REPEAT_TICKS > 0 ? $clog2(REPEAT_TICKS + 1) : 1;
    logic [1:0] sync;
    logic [DW-1:0] deb_cnt;
    logic [LW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    ch_state_t state;
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sync <= '0;
            deb_cnt <= '0;
            hold_cnt <= '0;
            rep_cnt <= '0;
            state <= IDLE;
            lvl <= 1'b0;
            press <= 1'b0;
            rel <= 1'b0;
            lng <= 1'b0;
            rpt <= 1'b0;
        end else begin
            sync <= {sync[0], ACTIVE_HIGH != 0 ? key_raw : ~key_raw};
            press <= 1'b0;
            rel <= 1'b0;
            lng <= 1'b0;
            rpt <= 1'b0;
            if (tick) begin
                // a level flip takes priority over hold/repeat bookkeeping on the same tick
                if (sync[1] != lvl && deb_cnt == DW'(DEB_TICKS - 1)) begin
                    deb_cnt <= '0;
                    lvl <= sync[1];
                    hold_cnt <= '0;
                    rep_cnt <= '0;
                    press <= sync[1];
                    rel <= ~sync[1];
                    state <= sync[1] ? HELD : IDLE;
                end else begin
                    deb_cnt <= sync[1] != lvl ? deb_cnt + 1'b1 : '0;
                    case (state)
                        HELD: begin
                            hold_cnt <= hold_cnt + 1'b1;
                            if (hold_cnt == LW'(LONG_TICKS - 1)) begin
                                lng <= 1'b1;
                                rep_cnt <= '0;
                                state <= REPEAT;
                            end
                        end
                        REPEAT: begin
                            if (REPEAT_TICKS > 0) begin
                                rpt <= rep_cnt == RW'(REPEAT_TICKS - 1);
                                rep_cnt <= rep_cnt == RW'(REPEAT_TICKS - 1) ? '0 : rep_cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: rtl/key_scan_mc.sv
// key_scan_mc: N-channel key conditioner with shared sample tick and priority key code
module key_scan_mc
    import key_scan_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_DIV     = 50_000,
    parameter int DEB_TICKS    = 20,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int ACTIVE_HIGH  = 1
) (
    input  logic                               clk_in,
    input  logic                               rst,
    input  logic [NUM_KEYS-1:0]                key_in,
    output logic [NUM_KEYS-1:0]                key_level,
    output logic [NUM_KEYS-1:0]                key_press,
    output logic [NUM_KEYS-1:0]                key_release,
    output logic [NUM_KEYS-1:0]                key_long,
    output logic [NUM_KEYS-1:0]                key_repeat,
    output logic [code_width(NUM_KEYS)-1:0]    key_code,
    output logic                               key_pressed_out,
    output logic                               key_multi
);
    localparam int CW = code_width(NUM_KEYS);
    localparam int TW = $clog2(TICK_DIV);
    logic [TW-1:0] tick_cnt;
    logic tick;
    logic [CW-1:0] code_n;
    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    always_ff @(posedge clk_in) begin
        if (!rst) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_scan_ch #(
            .DEB_TICKS(DEB_TICKS),
            .LONG_TICKS(LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .ACTIVE_HIGH(ACTIVE_HIGH)
        ) u_ch (
            .clk_in(clk_in),
            .rst(rst),
            .tick(tick),
            .key_raw(key_in[i]),
            .lvl(key_level[i]),
            .press(key_press[i]),
            .rel(key_release[i]),
            .lng(key_long[i]),
            .rpt(key_repeat[i])
        );
    end
    // scan downwards so the lowest-index pressed key wins
    always_comb begin
        code_n = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (key_level[i]) code_n = CW'(i + 1);
    end
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            key_code <= '0;
            key_pressed_out <= 1'b0;
            key_multi <= 1'b0;
        end else begin
            key_code <= code_n;
            key_pressed_out <= |key_level;
            key_multi <= (key_level & (key_level - 1'b1)) != '0;
        end
    end
endmodule

// File: tb/tb_key_scan_mc.sv
// tb_key_scan_mc: random and directed stimulus checked against a tick-level key model
module tb_key_scan_mc;
    localparam int N = 4, TD = 4, DEB = 3, LONG = 10, REP = 4;
    logic clk_in = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] key_in = '0, key_in_b = '1;
    logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;
    logic [N-1:0] lvl_b, press_b, rel_b, long_b, rep_b;
    logic [2:0] key_code, code_b;
    logic key_pressed_out, key_multi, any_b, multi_b;
    int total = 0, bad = 0;
    // reference model state, valid after each clock edge
    logic [N-1:0] m_s0, m_s1, m_lvl, m_press, m_rel, m_long, m_rep;
    logic [2:0] m_code;
    logic m_any, m_multi;
    int m_tcnt, m_run[N], m_age[N];
    int cnt_long1, cnt_rep1, cnt_ev2, cnt_rel0;
    always #5 clk_in = ~clk_in;
    key_scan_mc #(.NUM_KEYS(N), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG),
                  .REPEAT_TICKS(REP), .ACTIVE_HIGH(1)) dut (
        .clk_in(clk_in), .rst(rst), .key_in(key_in), .key_level(key_level),
        .key_press(key_press), .key_release(key_release), .key_long(key_long),
        .key_repeat(key_repeat), .key_code(key_code), .key_pressed_out(key_pressed_out),
        .key_multi(key_multi));
    key_scan_mc #(.NUM_KEYS(N), .TICK_DIV(TD), .DEB_TICKS(DEB), .LONG_TICKS(LONG),
                  .REPEAT_TICKS(REP), .ACTIVE_HIGH(0)) dut_lo (
        .clk_in(clk_in), .rst(rst), .key_in(key_in_b), .key_level(lvl_b),
        .key_press(press_b), .key_release(rel_b), .key_long(long_b),
        .key_repeat(rep_b), .key_code(code_b), .key_pressed_out(any_b),
        .key_multi(multi_b));
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask
    task automatic model(input logic [N-1:0] kin, input logic r);
        logic tick;
        if (!r) begin
            {m_s0, m_s1, m_lvl, m_press, m_rel, m_long, m_rep} = '0;
            m_code = '0; m_any = 1'b0; m_multi = 1'b0; m_tcnt = 0;
            for (int k = 0; k < N; k++) begin m_run[k] = 0; m_age[k] = 0; end
            return;
        end
        tick = m_tcnt == TD - 1;
        m_code = '0;
        for (int k = N - 1; k >= 0; k--) if (m_lvl[k]) m_code = 3'(k + 1);
        m_any = m_lvl != 0;
        m_multi = $countones(m_lvl) > 1;
        {m_press, m_rel, m_long, m_rep} = '0;
        for (int k = 0; k < N; k++) if (tick) begin
            if (m_s1[k] != m_lvl[k]) m_run[k]++; else m_run[k] = 0;
            if (m_run[k] == DEB) begin
                m_run[k] = 0;
                m_lvl[k] = m_s1[k];
                m_press[k] = m_s1[k];
                m_rel[k] = ~m_s1[k];
                m_age[k] = 0;
            end else if (m_lvl[k]) begin
                m_age[k]++;
                m_long[k] = m_age[k] == LONG;
                m_rep[k] = m_age[k] > LONG && (m_age[k] - LONG) % REP == 0;
            end
        end
        m_s1 = m_s0;
        m_s0 = kin;
        m_tcnt = tick ? 0 : m_tcnt + 1;
    endtask
    task automatic step(input logic [N-1:0] kin, input logic r);
        @(negedge clk_in);
        key_in = kin;
        key_in_b = ~kin;
        rst = r;
        model(kin, r);
        @(posedge clk_in);
        #1;
        check("level", key_level, m_lvl);
        check("press", key_press, m_press);
        check("release", key_release, m_rel);
        check("long", key_long, m_long);
        check("repeat", key_repeat, m_rep);
        check("code", key_code, m_code);
        check("any", key_pressed_out, m_any);
        check("multi", key_multi, m_multi);
        check("lo_level", lvl_b, m_lvl);
        check("lo_press", press_b, m_press);
        check("lo_code", code_b, m_code);
        check("lo_repeat", rep_b, m_rep);
        cnt_long1 += key_long[1];
        cnt_rep1 += key_repeat[1];
        cnt_ev2 += key_press[2] + key_release[2] + key_level[2];
        cnt_rel0 += key_release[0];
    endtask
    initial begin
        logic [N-1:0] pat;
        int dur, per;
        cnt_long1 = 0; cnt_rep1 = 0; cnt_ev2 = 0; cnt_rel0 = 0;
        repeat (3) step('0, 1'b0);
        repeat (40) step(4'b0001, 1'b1);
        repeat (40) step('0, 1'b1);
        for (int t = 0; t < 10; t++) begin
            repeat (8) step(4'b0100, 1'b1);
            repeat (8) step('0, 1'b1);
        end
        check("glitch_events", cnt_ev2, 0);
        repeat (132) step(4'b0010, 1'b1);
        repeat (40) step('0, 1'b1);
        check("long1_count", cnt_long1, 1);
        check("repeat1_count", cnt_rep1, 5);
        repeat (60) step(4'b1010, 1'b1);
        repeat (30) step('0, 1'b1);
        repeat (70) step(4'b0001, 1'b1);
        cnt_rel0 = 0;
        step(4'b0001, 1'b0);
        repeat (40) step(4'b0001, 1'b1);
        check("reset_no_release", cnt_rel0, 0);
        repeat (30) step('0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            pat = 4'($urandom_range(0, 15));
            dur = $urandom_range(1, 160);
            per = $urandom_range(1, 12);
            if ($urandom_range(0, 14) == 0) step(pat, 1'b0);
            else if ($urandom_range(0, 7) == 0)
                for (int c = 0; c < dur; c++) step((c / per) % 2 ? pat : '0, 1'b1);
            else
                repeat (dur) step(pat, 1'b1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_scan_mc.md
# key_scan_mc

Parametrised multi-channel key conditioner: synchronises N raw key inputs, debounces each on a shared slow sample tick, and produces debounced levels plus press, release, long-press and auto-repeat event pulses. A 1-based encoded key code and "any pressed" / "multi pressed" flags are also produced. It sits between the board push-buttons and the control FSMs, for example for AM parameter selection.

## Interface
Parameters:
- NUM_KEYS, 4, number of key channels (1..16)
- TICK_DIV, 50_000, clk_in cycles per sample tick (≥2)
- DEB_TICKS, 20, consecutive agreeing ticks needed to change a debounced level (≥1)
- LONG_TICKS, 1000, ticks held before key_long fires (≥1)
- REPEAT_TICKS, 200, tick period of key_repeat after key_long; 0 disables repeat
- ACTIVE_HIGH, 1, 1: key_in high = pressed; 0: low = pressed

Ports:
- clk_in  in  1  system clock; the block's only clock
- rst  in  1  reset; synchronous, active-low
- key_in  in  NUM_KEYS  raw asynchronous key inputs
- key_level  out  NUM_KEYS  debounced state, 1 = pressed
- key_press  out  NUM_KEYS  1-cycle pulse on the debounced press edge
- key_release  out  NUM_KEYS  1-cycle pulse on the debounced release edge
- key_long  out  NUM_KEYS  1-cycle pulse when the hold reaches LONG_TICKS
- key_repeat  out  NUM_KEYS  1-cycle pulse every REPEAT_TICKS after key_long while held
- key_code  out  CW=$clog2(NUM_KEYS+1)  index+1 of the lowest-index pressed key; 0 = none
- key_pressed_out  out  1  OR of key_level
- key_multi  out  1  more than one key_level bit set

## Operation
- Polarity: raw inputs are normalised by ACTIVE_HIGH, then passed through a 2-flop synchroniser per channel.
- Tick: a free-running counter runs 0..TICK_DIV-1. The tick is 1 for one cycle when the count is TICK_DIV-1, and the counter then wraps to 0.
- Per-channel FSM, with states IDLE, HELD, REPEAT:
  - The debounce counter advances only on a tick where the synced sample differs from key_level. On any tick where they agree, it is cleared.
  - When the count reaches DEB_TICKS, key_level flips and the counter clears.
  - IDLE→HELD on a press flip; key_press pulses and hold_cnt clears.
  - In HELD, hold_cnt increments on each tick. When hold_cnt reaches LONG_TICKS, key_long pulses and the FSM enters REPEAT with rep_cnt cleared.
  - In REPEAT, rep_cnt increments on each tick. When it reaches REPEAT_TICKS, key_repeat pulses and rep_cnt clears.
  - If REPEAT_TICKS=0, the FSM stays in REPEAT silently.
  - HELD or REPEAT→IDLE on a release flip; key_release pulses and the hold and repeat counters clear.
- key_code, key_pressed_out and key_multi are registered from the current key_level. They lag key_level by one cycle.
- Counter widths are $clog2(param+1). Counters never exceed their terminal value.
- Channels are fully independent. Simultaneous flips on several channels in the same tick each produce their own pulses.

## Timing
- Reset (rst=0 at a clk_in edge) clears all of the following to 0 on that edge:
  - every output
  - synchronisers, tick counter, all per-channel counters
  - all FSMs, which go to IDLE
- Reset mid-hold emits no key_release.
- A key still held when reset deasserts is debounced as a fresh press.
- Press latency from a clean input edge: 2 synchroniser cycles, then DEB_TICKS ticks. key_level and key_press update on the same edge.
- key_long fires exactly LONG_TICKS ticks after the press tick. Each key_repeat then follows every REPEAT_TICKS ticks.
- All event pulses last exactly one clk_in cycle and align with a tick edge.
- key_press and key_release never occur in the same cycle for one channel.
- A release in the same tick that hold_cnt reaches LONG_TICKS: the release wins, and no key_long pulse is emitted.

## Structure
- Package key_scan_pkg holds:
  - the channel state enum (IDLE, HELD, REPEAT)
  - the function code_width(n) = $clog2(n+1)
- Sub-module key_scan_ch: one channel, containing the synchroniser, debounce counter, FSM, hold and repeat counters. It takes tick as an input.
- Top key_scan_mc holds the tick divider, a generate loop over key_scan_ch, and the priority encoder with its flags.

## Test plan
Bench parameters: TICK_DIV=4, DEB_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=4, NUM_KEYS=4.
- key_in[0]=1 held clean, ACTIVE_HIGH=1 -> key_press[0] pulses once, 3 ticks after sync. key_level=4'b0001, then key_code=1 and key_pressed_out=1 one cycle later.
- key_in[2] toggles every 2 ticks for 20 ticks -> no key_press or key_release pulses; key_level stays 0.
- key_in[1] held for 30 ticks, then released -> key_long[1] at hold tick 10, key_repeat[1] at ticks 14, 18, 22, 26, 30. key_release[1] follows 3 ticks after the release, with no further repeats.
- key_in[1] and key_in[3] pressed together -> both key_press bits pulse in the same cycle. key_code=2, key_multi=1.
- rst=0 for 1 cycle while key 0 is in REPEAT -> all outputs 0 on the next edge, with no release pulse. A key still held afterwards gives a new key_press after 3 ticks.
- ACTIVE_HIGH=0, key_in=4'b1110 -> key_press[0] and key_code=1.
